// File: rtl/multi_glitch_filter.sv
// Multi-channel debounce/glitch filter: per-line 2-flop synchronizer, stability
// counter against a shared threshold, edge pulses and sticky toggle flags.
module multi_glitch_filter #(
  parameter int                  CHANNELS = 2,
  parameter int                  CNT_W    = 5,
  parameter logic [CHANNELS-1:0] RST_VAL  = {CHANNELS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] inp,
  input  logic [CNT_W-1:0]    thresh,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] flag
);

  // Last count value at which a disagreeing sample toggles; thresh==0 acts as 1.
  function automatic logic [CNT_W-1:0] f_limit(input logic [CNT_W-1:0] t);
    f_limit = (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  logic [CHANNELS-1:0] r_sync_p0;
  logic [CHANNELS-1:0] r_sync_p1;
  logic [CHANNELS-1:0] r_out;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] r_flag;
  logic [CHANNELS-1:0] w_tog;
  logic [CNT_W-1:0]    w_lim;

  assign w_lim = f_limit(thresh);

  // Stage p0/p1: synchronizer on the raw asynchronous lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= RST_VAL;
      r_sync_p1 <= RST_VAL;
    end else begin
      r_sync_p0 <= inp;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stability counters: one per channel, cleared on agreement or on toggle
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             w_dis;

    assign w_dis    = r_sync_p1[g] ^ r_out[g];
    assign w_tog[g] = w_dis && (r_cnt >= w_lim);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (!w_dis || w_tog[g]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Filtered level, edge pulses and sticky flags; a toggle beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_flag <= '0;
    end else begin
      r_out  <= r_out ^ w_tog;
      r_rise <= w_tog & r_sync_p1;
      r_fall <= w_tog & ~r_sync_p1;
      r_flag <= w_tog | (r_flag & ~clr);
    end
  end

  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;
  assign flag = r_flag;

endmodule

// File: doc/multi_glitch_filter.md
MULTI_GLITCH_FILTER -- requirements
Module: multi_glitch_filter

Interface
REQ-001 Parameter: CHANNELS, default 2, number of independent filtered lines (e.g. SCL, SDA).
REQ-002 Parameter: CNT_W, default 5, width of stability counter and of thresh.
REQ-003 Parameter: RST_VAL, default {CHANNELS{1'b1}}, reset value of out (I2C idle-high).
REQ-004 Port: clk  input  1  sole clock, all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: inp  input  CHANNELS  raw asynchronous lines.
REQ-007 Port: thresh  input  CNT_W  required consecutive disagreeing samples before out toggles; quasi-static.
REQ-008 Port: clr  input  CHANNELS  per-channel write-1-to-clear for flag.
REQ-009 Port: out  output  CHANNELS  filtered level, registered.
REQ-010 Port: rise  output  CHANNELS  one-cycle pulse, out went 0->1.
REQ-011 Port: fall  output  CHANNELS  one-cycle pulse, out went 1->0.
REQ-012 Port: flag  output  CHANNELS  sticky "out toggled since last clear".

Function
REQ-013 Each channel SHALL pass inp[i] through a 2-flop synchronizer; filtered sample s[i] = second flop.
REQ-014 Channels SHALL be fully independent; shared only: clk, rst_n, thresh.
REQ-015 Effective threshold T SHALL be thresh, except thresh==0 SHALL be treated as T=1.
REQ-016 Per channel, CNT_W-bit counter cnt: if s==out, cnt SHALL clear to 0 on next edge.
REQ-017 If s!=out and cnt<T-1, cnt SHALL increment by 1.
REQ-018 If s!=out and cnt>=T-1, out SHALL take s, cnt SHALL clear to 0, same edge.
REQ-019 Counter SHALL never wrap; the cnt>=T-1 comparison covers thresh lowered mid-count (toggle on next disagreeing edge).
REQ-020 Latency: inp change sampled at edge k, held stable, SHALL appear on out after edge k+1+T.
REQ-021 A disagreement lasting fewer than T consecutive s-samples SHALL leave out unchanged and reset cnt.
REQ-022 rise[i]/fall[i] SHALL be high for exactly the one cycle following the edge at which out[i] toggled; never both high.
REQ-023 flag[i] SHALL set on the edge out[i] toggles; SHALL clear on an edge where clr[i]=1 and no toggle occurs.
REQ-024 Simultaneous toggle and clr[i] on the same edge: set SHALL win, flag[i]=1.
REQ-025 Maximum T = 2^CNT_W - 1; no larger value representable.

Reset
REQ-026 rst_n low SHALL asynchronously force: out=RST_VAL, both synchronizer flops=RST_VAL, cnt=0, rise=0, fall=0, flag=0.
REQ-027 Reset asserted mid-count SHALL discard the count; after release filtering SHALL restart from RST_VAL with cnt=0.
REQ-028 First edge after rst_n release SHALL be a normal operating edge; no pulse SHALL be generated by reset itself.

Verification
REQ-029 CHANNELS=2, thresh=4, inp=2'b11 from reset; inp[0] falls before edge 10 and stays -> out[0]=0 after edge 15, fall[0] high one cycle, flag[0]=1, out[1] stays 1.
REQ-030 thresh=4, inp[1] low glitch 3 cycles wide -> out[1] stays 1, no fall, flag[1]=0; repeat with 4-cycle-wide glitch -> out[1] drops then returns, one fall and one rise pulse.
REQ-031 thresh=0 -> behaves as T=1: step on inp[0] at edge k appears on out[0] after edge k+2.
REQ-032 Toggle on out[0] on the same edge clr[0]=1 -> flag[0]=1; clr[0]=1 next cycle with no toggle -> flag[0]=0.
REQ-033 thresh=8, inp[0] held low, rst_n pulsed low after 5 counting cycles -> out[0]=1, cnt=0 immediately; after release, out[0] falls only after a full 8 further samples (edge r+1+8 relative to first sampling edge r).
REQ-034 thresh=31 (CNT_W=5) sustained change -> out toggles after edge k+32, cnt never exceeds 30, no wrap.
